instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- IF pipeline stage; producer end of the IF→ID link, driving instr and pc into the ID stage.
- Owns the PC register and issues one-at-a-time requests to instruction memory over a req/gnt/rvalid handshake.
- Obeys pc_src/branch_pc redirect and flush/en_pc/en_IF stall controls returned from the ID stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word presented to ID when the stage is empty or flushed.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- pc_src  in  1  branch taken in ID; redirect fetch.
- branch_pc  in  32  redirect target; bits [1:0] ignored (forced 0).
- flush  in  1  invalidate IF/ID contents.
- en_pc  in  1  PC advance enable (0 = load-use stall).
- en_IF  in  1  IF/ID register load enable (0 = hold).
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; word aligned.
- imem_gnt  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  response valid; at least 1 cycle after gnt.
- imem_rdata  in  32  fetched instruction.
- if_pc  out  32  PC of instruction in IF/ID (to ID branch adder).
- if_instr  out  32  instruction in IF/ID.
- if_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_pc=0, if_instr=NOP_INSTR, if_valid=0, fetch buffer empty, state IDLE.
- Single outstanding request.
  - imem_req, once high, stays high with imem_addr stable until imem_gnt.
  - Grant on the first cycle of req is legal.
- States:
  - IDLE: buffer not full → next cycle REQ with imem_addr=pc.
  - REQ: gnt → WAIT.
  - WAIT: rvalid → IDLE.
  - DROP: discard next rvalid → IDLE.
- Stale requests:
  - Redirect while in REQ marks the request stale; on gnt go to DROP instead of WAIT.
  - Redirect while in WAIT → DROP.
- Redirect (pc_src=1):
  - pc <= {branch_pc[31:2],2'b00}, overriding en_pc.
  - IF/ID and fetch buffer cleared the same edge, as for flush.
- Accepted response (WAIT, rvalid):
  - en_IF=1 and buffer empty: if_instr<=rdata, if_pc<=fetch addr, if_valid<=1 next edge.
  - en_IF=0: store {addr,rdata} in one-entry fetch buffer; no new request while buffer full.
  - Buffer drains into IF/ID on the first en_IF=1 cycle; a new request may issue the same cycle.
- PC advance: pc <= pc+4 on each accepted response when en_pc=1; modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- en_pc=0 and en_IF=0 both: no state change except acceptance into an empty buffer.
- flush=1 (without pc_src): if_valid<=0, if_instr<=NOP_INSTR, buffer cleared; a response arriving the same cycle is dropped.
  - Priority: rst_n > pc_src > flush > en_IF load.
- Latency: IF/ID valid at earliest 2 cycles after imem_req rises (gnt same cycle, rvalid next).
- Reset mid-transaction: all state returns to reset values immediately; a late rvalid after reset release with no request outstanding is ignored.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt[31:0] and drop_cnt[31:0].
  - fetch_cnt: responses loaded into IF/ID or the buffer.
  - drop_cnt: responses discarded in DROP or by flush.
  - Both count saturating at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package if_pkg holds:
  - fetch_state_t enum {IDLE, REQ, WAIT, DROP};
  - NOP_INSTR default constant;
  - PC_INC = 32'd4.
- One sub-module: fetch_buffer, a one-entry {pc,instr} skid register with load/drain/clear.

Test Plan:
- Reset release, gnt immediate, rvalid 1 cycle later, rdata 32'h2002_0005 → if_instr=32'h2002_0005, if_pc=0, if_valid=1; next imem_addr=4.
- en_IF=0 for 3 cycles while response 32'hAAAA_0001 arrives → buffered, no new imem_req; on en_IF=1, if_instr=32'hAAAA_0001, then request addr+4.
- pc_src=1, branch_pc=32'h0000_0103 while in WAIT → response dropped, IF/ID empty, next imem_addr=32'h0000_0100.
- pc=32'hFFFF_FFFC, response accepted → next imem_addr=32'h0000_0000.
- gnt withheld 4 cycles → imem_req and imem_addr stable throughout; flush during wait leaves request intact, clears if_valid.
- rst_n pulsed low during WAIT → outputs at reset values asynchronously; later stray rvalid ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_t     - request FSM states
//   fetch_entry_t     - {pc, instr} pair carried by IF/ID and the skid buffer
//   NOP_INSTR_DEFAULT - bubble instruction word
//   PC_INC            - sequential PC step
// ---------------------------------------------------------------------------
package if_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DROP = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_INC            = 32'd4;

endpackage

// File: rtl/instruction_fetch_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_if: instruction memory req/gnt/rvalid bus.
//   imem_req    - fetch request valid (master -> slave)
//   imem_addr   - word-aligned fetch address (master -> slave)
//   imem_gnt    - request accepted this cycle (slave -> master)
//   imem_rvalid - response valid, at least one cycle after gnt (slave -> master)
//   imem_rdata  - fetched instruction (slave -> master)
// ---------------------------------------------------------------------------
interface instruction_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata
   );
endinterface

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer: one-entry {pc, instr} skid register. Catches a response that
// arrives while IF/ID is held, and drains it once IF/ID loads again.
//   clk, rst_n - clock, async active-low reset
//   load_i     - capture entry_i (buffer must be empty)
//   drain_i    - entry consumed by IF/ID
//   clear_i    - discard contents (redirect/flush), wins over load/drain
//   entry_i    - incoming {pc, instr}
//   full_o     - buffer holds an entry
//   entry_o    - stored {pc, instr}
// ---------------------------------------------------------------------------
module fetch_buffer
   import if_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         drain_i,
   input  logic         clear_i,
   input  fetch_entry_t entry_i,
   output logic         full_o,
   output fetch_entry_t entry_o
);

   logic         full_q;
   fetch_entry_t entry_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q  <= 1'b0;
         entry_q <= '0;
      end else if (clear_i) begin
         full_q  <= 1'b0;
      end else if (load_i) begin
         full_q  <= 1'b1;
         entry_q <= entry_i;
      end else if (drain_i) begin
         full_q  <= 1'b0;
      end
   end

   assign full_o  = full_q;
   assign entry_o = entry_q;

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch: IF pipeline stage. Owns the PC, issues one outstanding
// request at a time to instruction memory and feeds the IF/ID register.
//   clk, rst_n     - clock, async active-low reset
//   pc_src_i       - branch taken in ID, redirect to branch_pc_i
//   branch_pc_i    - redirect target, bits [1:0] ignored
//   flush_i        - invalidate IF/ID and the fetch buffer
//   en_pc_i        - PC advance enable (0 = load-use stall)
//   en_IF_i        - IF/ID load enable (0 = hold)
//   imem           - instruction memory bus (master side)
//   if_pc_o        - PC of the instruction in IF/ID
//   if_instr_o     - instruction in IF/ID
//   if_valid_o     - IF/ID holds a real instruction
// Optional (macro IF_PERF_CNT_EN):
//   fetch_cnt_o    - responses loaded into IF/ID or the buffer (saturating)
//   drop_cnt_o     - responses discarded by DROP or flush/redirect (saturating)
// ---------------------------------------------------------------------------
module instruction_fetch
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pc_src_i,
   input  logic [31:0]         branch_pc_i,
   input  logic                flush_i,
   input  logic                en_pc_i,
   input  logic                en_IF_i,
   instruction_fetch_if.master imem,
   output logic [31:0]         if_pc_o,
   output logic [31:0]         if_instr_o,
   output logic                if_valid_o
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]         fetch_cnt_o,
   output logic [31:0]         drop_cnt_o
`endif
);

   localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

   fetch_state_t state_q, state_d;
   logic         stale_q, stale_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  addr_q, addr_d;
   logic [31:0]  if_pc_q, if_pc_d;
   logic [31:0]  if_instr_q, if_instr_d;
   logic         if_valid_q, if_valid_d;

   logic         kill, rsp_wait, accept, can_issue;
   logic         buf_full, buf_load, buf_drain;
   fetch_entry_t buf_in, buf_out;
   logic         unused_bpc;

   assign unused_bpc = ^branch_pc_i[1:0];

   // Redirect and flush both clear IF/ID and the buffer, and both discard a
   // response arriving in the same cycle.
   assign kill     = pc_src_i | flush_i;
   assign rsp_wait = (state_q == WAIT) && imem.imem_rvalid;
   assign accept   = rsp_wait && !kill;

   assign buf_load  = accept && !en_IF_i;
   assign buf_drain = en_IF_i && buf_full && !kill;

   // Issue from IDLE unless fully stalled (a redirect still refetches), and
   // only if the buffer will have room after this edge.
   assign can_issue = (pc_src_i || en_pc_i || en_IF_i) &&
                      (!buf_full || en_IF_i || kill);

   assign buf_in.pc    = addr_q;
   assign buf_in.instr = imem.imem_rdata;

   fetch_buffer u_fetch_buffer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (buf_load),
      .drain_i (buf_drain),
      .clear_i (kill),
      .entry_i (buf_in),
      .full_o  (buf_full),
      .entry_o (buf_out)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         stale_q <= 1'b0;
      end else begin
         state_q <= state_d;
         stale_q <= stale_d;
      end
   end

   // ---------------- FSM: next state ----------------
   // A redirect while the request is still waiting for gnt cannot retract it
   // (req must stay stable), so remember it and route the grant to DROP.
   always_comb begin
      state_d = state_q;
      stale_d = 1'b0;
      case (state_q)
         IDLE: if (can_issue) state_d = REQ;
         REQ: begin
            if (imem.imem_gnt) state_d = (stale_q || pc_src_i) ? DROP : WAIT;
            else               stale_d = stale_q || pc_src_i;
         end
         // rvalid with a redirect in the same cycle is dropped right here;
         // going to DROP would wait for a response that never comes.
         WAIT: begin
            if (imem.imem_rvalid) state_d = IDLE;
            else if (pc_src_i)    state_d = DROP;
         end
         DROP: if (imem.imem_rvalid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      imem.imem_req  = (state_q == REQ);
      imem.imem_addr = addr_q;
   end

   // ---------------- PC / address / IF-ID datapath ----------------
   always_comb begin
      pc_d = pc_q;
      if (pc_src_i)              pc_d = {branch_pc_i[31:2], 2'b00};
      else if (accept && en_pc_i) pc_d = pc_q + PC_INC;

      addr_d = ((state_q == IDLE) && can_issue) ? pc_d : addr_q;

      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      if_valid_d = if_valid_q;
      if (kill) begin
         if_instr_d = NOP_INSTR;
         if_valid_d = 1'b0;
      end else if (en_IF_i) begin
         if (buf_full) begin
            if_pc_d    = buf_out.pc;
            if_instr_d = buf_out.instr;
            if_valid_d = 1'b1;
         end else if (accept) begin
            if_pc_d    = addr_q;
            if_instr_d = imem.imem_rdata;
            if_valid_d = 1'b1;
         end else begin
            // ID consumed the previous entry; nothing new, so insert a bubble.
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC_AL;
         addr_q     <= RESET_PC_AL;
         if_pc_q    <= '0;
         if_instr_q <= NOP_INSTR;
         if_valid_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         if_valid_q <= if_valid_d;
      end
   end

   assign if_pc_o    = if_pc_q;
   assign if_instr_o = if_instr_q;
   assign if_valid_o = if_valid_q;

`ifdef IF_PERF_CNT_EN
   logic        dropped;
   logic [31:0] fetch_cnt_q, drop_cnt_q;

   assign dropped = ((state_q == DROP) && imem.imem_rvalid) || (rsp_wait && kill);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (accept  && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (dropped && (drop_cnt_q  != '1)) drop_cnt_q  <= drop_cnt_q  + 32'd1;
      end
   end

   assign fetch_cnt_o = fetch_cnt_q;
   assign drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch: directed bench for instruction_fetch. The bench plays
// the memory side of the bus by hand, cycle by cycle. Inputs change and
// outputs are sampled 1 time unit after the rising edge.
// Optional ports are connected when IF_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        pc_src, flush, en_pc, en_IF;
   logic [31:0] branch_pc;
   logic [31:0] if_pc, if_instr;
   logic        if_valid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt, drop_cnt;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   instruction_fetch_if mif ();

   instruction_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc_src_i    (pc_src),
      .branch_pc_i (branch_pc),
      .flush_i     (flush),
      .en_pc_i     (en_pc),
      .en_IF_i     (en_IF),
      .imem        (mif),
      .if_pc_o     (if_pc),
      .if_instr_o  (if_instr),
      .if_valid_o  (if_valid)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_cnt_o (fetch_cnt),
      .drop_cnt_o  (drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; pc_src = 1'b0; flush = 1'b0; en_pc = 1'b1; en_IF = 1'b1;
      branch_pc = '0;
      mif.imem_gnt = 1'b0; mif.imem_rvalid = 1'b0; mif.imem_rdata = '0;
      #2 rst_n = 1'b0;
      #1;
      vec_cnt++; if (mif.imem_req !== 1'b0) begin err_cnt++; $display("FAIL rst_req got=%0h exp=0", mif.imem_req); end
      vec_cnt++; if (mif.imem_addr !== 32'h0) begin err_cnt++; $display("FAIL rst_addr got=%h exp=00000000", mif.imem_addr); end
      vec_cnt++; if (if_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid got=%0h exp=0", if_valid); end
      vec_cnt++; if (if_instr !== NOP) begin err_cnt++; $display("FAIL rst_instr got=%h exp=%h", if_instr, NOP); end
      vec_cnt++; if (if_pc !== 32'h0) begin err_cnt++; $display("FAIL rst_pc got=%h exp=00000000", if_pc); end
      tick(); tick();
      rst_n = 1'b1;
   endtask

   // Grant on the first req cycle, rvalid the next: valid 2 cycles after req.
   task automatic test_basic();
      tick();
      vec_cnt++; if (mif.imem_req !== 1'b1) begin err_cnt++; $display("FAIL basic_req got=%0h exp=1", mif.imem_req); end
      vec_cnt++; if (mif.imem_addr !== 32'h0) begin err_cnt++; $display("FAIL basic_addr got=%h exp=00000000", mif.imem_addr); end
      mif.imem_gnt = 1'b1;
      tick();
      mif.imem_gnt = 1'b0;
      vec_cnt++; if (mif.imem_req !== 1'b0) begin err_cnt++; $display("FAIL basic_req_drop got=%0h exp=0", mif.imem_req); end
      mif.imem_rvalid = 1'b1; mif.imem_rdata = 32'h2002_0005;
      tick();
      mif.imem_rvalid = 1'b0;
      vec_cnt++; if (if_instr !== 32'h2002_0005) begin err_cnt++; $display("FAIL basic_instr got=%h exp=20020005", if_instr); end
      vec_cnt++; if (if_pc !== 32'h0) begin err_cnt++; $display("FAIL basic_pc got=%h exp=00000000", if_pc); end
      vec_cnt++; if (if_valid !== 1'b1) begin err_cnt++; $display("FAIL basic_valid got=%0h exp=1", if_valid); end
      tick();
      vec_cnt++; if (mif.imem_req !== 1'b1) begin err_cnt++; $display("FAIL basic_req2 got=%0h exp=1", mif.imem_req); end
      vec_cnt++; if (mif.imem_addr !== 32'h4) begin err_cnt++; $display("FAIL basic_addr2 got=%h exp=00000004", mif.imem_addr); end
      vec_cnt++; if (if_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_bubble got=%0h exp=0", if_valid); end
   endtask

   task automatic test_buffer();
      mif.imem_gnt = 1'b1;
      tick();
      mif.imem_gnt = 1'b0;
      en_IF = 1'b0;
      mif.imem_rvalid = 1'b1; mif.imem_rdata = 32'hAAAA_0001;
      tick();
      mif.imem_rvalid = 1'b0;
      vec_cnt++; if (if_valid !== 1'b0) begin err_cnt++; $display("FAIL buf_hold_valid got=%0h exp=0", if_valid); end
      vec_cnt++; if (if_instr !== NOP) begin err_cnt++; $display("FAIL buf_hold_instr got=%h exp=%h", if_instr, NOP); end
      for (int i = 0; i < 3; i++) begin
         vec_cnt++; if (mif.imem_req !== 1'b0) begin err_cnt++; $display("FAIL buf_noreq%0d got=%0h exp=0", i, mif.imem_req); end
         if (i < 2) tick();
      end
      en_IF = 1'b1;
      tick();
      vec_cnt++; if (if_instr !== 32'hAAAA_0001) begin err_cnt++; $display("FAIL buf_drain_instr got=%h exp=aaaa0001", if_instr); end
      vec_cnt++; if (if_pc !== 32'h4) begin err_cnt++; $display("FAIL buf_drain_pc got=%h exp=00000004", if_pc); end
      vec_cnt++; if (if_valid !== 1'b1) begin err_cnt++; $display("FAIL buf_drain_valid got=%0h exp=1", if_valid); end
      vec_cnt++; if (mif.imem_req !== 1'b1) begin err_cnt++; $display("FAIL buf_req got=%0h exp=1", mif.imem_req); end
      vec_cnt++; if (mif.imem_addr !== 32'h8) begin err_cnt++; $display("FAIL buf_addr got=%h exp=00000008", mif.imem_addr); end
   endtask

   task automatic test_redirect();
      en_IF = 1'b0;
      mif.imem_gnt = 1'b1;
      tick();
      mif.imem_gnt = 1'b0;
      vec_cnt++; if (if_valid !== 1'b1) begin err_cnt++; $display("FAIL redir_pre_valid got=%0h exp=1", if_valid); end
      pc_src = 1'b1; branch_pc = 32'h0000_0103;
      tick();
      pc_src = 1'b0; en_IF = 1'b1;
      vec_cnt++; if (if_valid !== 1'b0) begin err_cnt++; $display("FAIL redir_clr_valid got=%0h exp=0", if_valid); end
      vec_cnt++; if (if_instr !== NOP) begin err_cnt++; $display("FAIL redir_clr_instr got=%h exp=%h", if_instr, NOP); end
      mif.imem_rvalid = 1'b1; mif.imem_rdata = 32'hDEAD_BEEF;
      tick();
      mif.imem_rvalid = 1'b0;
      vec_cnt++; if (if_valid !== 1'b0) begin err_cnt++; $display("FAIL redir_drop_valid got=%0h exp=0", if_valid); end
      vec_cnt++; if (mif.imem_req !== 1'b0) begin err_cnt++; $display("FAIL redir_idle_req got=%0h exp=0", mif.imem_req); end
      tick();
      vec_cnt++; if (mif.imem_req !== 1'b1) begin err_cnt++; $display("FAIL redir_req got=%0h exp=1", mif.imem_req); end
      vec_cnt++; if (mif.imem_addr !== 32'h100) begin err_cnt++; $display("FAIL redir_addr got=%h exp=00000100", mif.imem_addr); end
   endtask

   // Redirect while the request still waits for gnt: req stays, grant is dropped.
   task automatic test_stale_req();
      pc_src = 1'b1; branch_pc = 32'hFFFF_FFFF;
      tick();
      pc_src = 1'b0;
      vec_cnt++; if (mif.imem_req !== 1'b1) begin err_cnt++; $display("FAIL stale_req got=%0h exp=1", mif.imem_req); end
      vec_cnt++; if (mif.imem_addr !== 32'h100) begin err_cnt++; $display("FAIL stale_addr got=%h exp=00000100", mif.imem_addr); end
      mif.imem_gnt = 1'b1;
      tick();
      mif.imem_gnt = 1'b0;
      mif.imem_rvalid = 1'b1; mif.imem_rdata = 32'h0000_1234;
      tick();
      mif.imem_rvalid = 1'b0;
      vec_cnt++; if (if_valid !== 1'b0) begin err_cnt++; $display("FAIL stale_drop_valid got=%0h exp=0", if_valid); end
      tick();
      vec_cnt++; if (mif.imem_addr !== 32'hFFFF_FFFC) begin err_cnt++; $display("FAIL stale_new_addr got=%h exp=fffffffc", mif.imem_addr); end
   endtask

   task automatic test_wrap();
      mif.imem_gnt = 1'b1;
      tick();
      mif.imem_gnt = 1'b0;
      mif.imem_rvalid = 1'b1; mif.imem_rdata = 32'h0000_0093;
      tick();
      mif.imem_rvalid = 1'b0;
      vec_cnt++; if (if_pc !== 32'hFFFF_FFFC) begin err_cnt++; $display("FAIL wrap_pc got=%h exp=fffffffc", if_pc); end
      vec_cnt++; if (if_instr !== 32'h0000_0093) begin err_cnt++; $display("FAIL wrap_instr got=%h exp=00000093", if_instr); end
      en_IF = 1'b0;
      tick();
      vec_cnt++; if (mif.imem_addr !== 32'h0) begin err_cnt++; $display("FAIL wrap_addr got=%h exp=00000000", mif.imem_addr); end
   endtask

   task automatic test_gnt_hold();
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         vec_cnt++; if (mif.imem_req !== 1'b1) begin err_cnt++; $display("FAIL hold_req%0d got=%0h exp=1", i, mif.imem_req); end
         vec_cnt++; if (mif.imem_addr !== 32'h0) begin err_cnt++; $display("FAIL hold_addr%0d got=%h exp=00000000", i, mif.imem_addr); end
         if (i == 1) begin
            vec_cnt++; if (if_valid !== 1'b1) begin err_cnt++; $display("FAIL hold_pre_valid got=%0h exp=1", if_valid); end
            flush = 1'b1;
         end else begin
            flush = 1'b0;
         end
         if (i == 2) begin
            vec_cnt++; if (if_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_valid got=%0h exp=0", if_valid); end
            vec_cnt++; if (if_instr !== NOP) begin err_cnt++; $display("FAIL flush_instr got=%h exp=%h", if_instr, NOP); end
         end
      end
      en_IF = 1'b1;
      mif.imem_gnt = 1'b1;
      tick();
      mif.imem_gnt = 1'b0;
   endtask

   task automatic test_reset_mid();
      mif.imem_rvalid = 1'b1; mif.imem_rdata = 32'h0000_0113;
      tick();
      mif.imem_rvalid = 1'b0;
      en_IF = 1'b0;
      vec_cnt++; if (if_instr !== 32'h0000_0113) begin err_cnt++; $display("FAIL rmid_instr got=%h exp=00000113", if_instr); end
      tick();
      vec_cnt++; if (mif.imem_addr !== 32'h4) begin err_cnt++; $display("FAIL rmid_addr got=%h exp=00000004", mif.imem_addr); end
      mif.imem_gnt = 1'b1;
      tick();
      mif.imem_gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      vec_cnt++; if (mif.imem_req !== 1'b0) begin err_cnt++; $display("FAIL rmid_req got=%0h exp=0", mif.imem_req); end
      vec_cnt++; if (mif.imem_addr !== 32'h0) begin err_cnt++; $display("FAIL rmid_rst_addr got=%h exp=00000000", mif.imem_addr); end
      vec_cnt++; if (if_valid !== 1'b0) begin err_cnt++; $display("FAIL rmid_valid got=%0h exp=0", if_valid); end
      vec_cnt++; if (if_instr !== NOP) begin err_cnt++; $display("FAIL rmid_rst_instr got=%h exp=%h", if_instr, NOP); end
`ifdef IF_PERF_CNT_EN
      vec_cnt++; if (fetch_cnt !== 32'h0) begin err_cnt++; $display("FAIL rmid_fcnt got=%0d exp=0", fetch_cnt); end
`endif
      #1 rst_n = 1'b1;
      en_IF = 1'b1;
      mif.imem_rvalid = 1'b1; mif.imem_rdata = 32'h0BAD_0BAD;
      tick();
      mif.imem_rvalid = 1'b0;
      vec_cnt++; if (if_valid !== 1'b0) begin err_cnt++; $display("FAIL stray_valid got=%0h exp=0", if_valid); end
      vec_cnt++; if (mif.imem_req !== 1'b1) begin err_cnt++; $display("FAIL restart_req got=%0h exp=1", mif.imem_req); end
      vec_cnt++; if (mif.imem_addr !== 32'h0) begin err_cnt++; $display("FAIL restart_addr got=%h exp=00000000", mif.imem_addr); end
      mif.imem_gnt = 1'b1;
      tick();
      mif.imem_gnt = 1'b0;
      mif.imem_rvalid = 1'b1; mif.imem_rdata = 32'h0000_0513;
      tick();
      mif.imem_rvalid = 1'b0;
      vec_cnt++; if (if_instr !== 32'h0000_0513) begin err_cnt++; $display("FAIL restart_instr got=%h exp=00000513", if_instr); end
      vec_cnt++; if (if_pc !== 32'h0) begin err_cnt++; $display("FAIL restart_pc got=%h exp=00000000", if_pc); end
`ifdef IF_PERF_CNT_EN
      vec_cnt++; if (fetch_cnt !== 32'h1) begin err_cnt++; $display("FAIL cnt_fetch got=%0d exp=1", fetch_cnt); end
      vec_cnt++; if (drop_cnt !== 32'h0) begin err_cnt++; $display("FAIL cnt_drop got=%0d exp=0", drop_cnt); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_buffer();
      test_redirect();
      test_stale_req();
      test_wrap();
      test_gnt_hold();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
